// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters.
// Ports: clk/rst; req{0,1}_{valid,ready,a,b,ctrl} request side;
//   resp{0,1}_{valid,ready,result,zero} registered response slots;
//   alu_busA/alu_busB/alu_aluCtrl to the ALU, alu_result/alu_zero from it.
// Optional: define ALU_ARB_PERF_EN to add perf_grant0/perf_grant1/perf_conflict.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 3,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict,
`endif
  output logic [DATA_W-1:0] alu_busA,
  output logic [DATA_W-1:0] alu_busB,
  output logic [CTRL_W-1:0] alu_aluCtrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic              ptr_q, ptr_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d;
  logic              z0_q, z0_d, z1_q, z1_d;

  // A full slot may still accept when it is being drained this cycle.
  assign elig0 = req0_valid && (!v0_q || resp0_ready) && !rst;
  assign elig1 = req1_valid && (!v1_q || resp1_ready) && !rst;

  // ptr_q == 0 favours port 0 on contention.
  assign grant0 = elig0 && (!elig1 || FIXED_PRIO || !ptr_q);
  assign grant1 = elig1 && !grant0;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_busA    = '0;
    alu_busB    = '0;
    alu_aluCtrl = '0;
    unique case (1'b1)
      grant0: begin
        alu_busA    = req0_a;
        alu_busB    = req0_b;
        alu_aluCtrl = req0_ctrl;
      end
      grant1: begin
        alu_busA    = req1_a;
        alu_busB    = req1_b;
        alu_aluCtrl = req1_ctrl;
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    v0_d  = v0_q;
    r0_d  = r0_q;
    z0_d  = z0_q;
    v1_d  = v1_q;
    r1_d  = r1_q;
    z1_d  = z1_q;
    // Pointer moves to the port that did not just win.
    if (grant0)      ptr_d = 1'b1;
    else if (grant1) ptr_d = 1'b0;
    if (grant0) begin
      v0_d = 1'b1;
      r0_d = alu_result;
      z0_d = alu_zero;
    end else if (resp0_ready) begin
      v0_d = 1'b0;
    end
    if (grant1) begin
      v1_d = 1'b1;
      r1_d = alu_result;
      z1_d = alu_zero;
    end else if (resp1_ready) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      v0_q  <= 1'b0;
      r0_q  <= '0;
      z0_q  <= 1'b0;
      v1_q  <= 1'b0;
      r1_q  <= '0;
      z1_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      v0_q  <= v0_d;
      r0_q  <= r0_d;
      z0_q  <= z0_d;
      v1_q  <= v1_d;
      r1_q  <= r1_d;
      z1_q  <= z1_d;
    end
  end

  assign resp0_valid  = v0_q;
  assign resp0_result = r0_q;
  assign resp0_zero   = z0_q;
  assign resp1_valid  = v1_q;
  assign resp1_result = r1_q;
  assign resp1_zero   = z1_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] pg0_q, pg0_d, pg1_q, pg1_d, pc_q, pc_d;

  always_comb begin
    pg0_d = pg0_q;
    pg1_d = pg1_q;
    pc_d  = pc_q;
    if (grant0 && pg0_q != 16'hFFFF)         pg0_d = pg0_q + 16'd1;
    if (grant1 && pg1_q != 16'hFFFF)         pg1_d = pg1_q + 16'd1;
    if (elig0 && elig1 && pc_q != 16'hFFFF)  pc_d  = pc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pc_q  <= '0;
    end else begin
      pg0_q <= pg0_d;
      pg1_q <= pg1_d;
      pc_q  <= pc_d;
    end
  end

  assign perf_grant0   = pg0_q;
  assign perf_grant1   = pg1_q;
  assign perf_conflict = pc_q;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle 32-bit ALU between two requesters, e.g. port 0 = execute stage and port 1 = multi-cycle address/branch helper.
- Arbitrates each cycle with valid/ready handshakes and drives the ALU operand and control inputs from the winner.
- Registers the ALU result and zero flag into a per-port response slot.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- CTRL_W, 3, ALU control width.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  port 0 op request
req0_ready  out  1  port 0 op accepted this cycle
req0_a  in  DATA_W  port 0 operand A
req0_b  in  DATA_W  port 0 operand B
req0_ctrl  in  CTRL_W  port 0 ALU op (000 add, 001 sub, 010 and, 011 or, 100 slt)
resp0_valid  out  1  port 0 result available
resp0_ready  in  1  port 0 consumes result
resp0_result  out  DATA_W  port 0 registered ALU result
resp0_zero  out  1  port 0 registered zero flag
req1_* / resp1_*  same set for port 1
alu_busA  out  DATA_W  to ALU operand A
alu_busB  out  DATA_W  to ALU operand B
alu_aluCtrl  out  CTRL_W  to ALU control
alu_result  in  DATA_W  from ALU result
alu_zero  in  1  from ALU zero

Behaviour:
- Eligibility:
  - elig_i = reqi_valid && (!respi_valid || respi_ready) && !rst.
  - A port with an undrained response slot is never granted.
- Arbitration (combinational):
  - Exactly one or zero grants per cycle.
  - If only one port is eligible, it wins.
  - If both are eligible and FIXED_PRIO=0, the port named by the priority pointer wins. The pointer flips to the other port after any grant. If there is no grant, the pointer holds.
  - If both are eligible and FIXED_PRIO=1, port 0 wins and the pointer is unused.
- Handshake:
  - reqi_ready = grant_i. Ready may depend on valid; requesters must not gate valid on ready.
  - A request transfers when valid && ready. Operands must be held stable while valid && !ready.
- ALU drive:
  - alu_busA, alu_busB and alu_aluCtrl are muxed from the winner.
  - With no grant, drive 0, 0, 000.
  - The ALU path is combinational through the arbiter: grant, then ALU, then capture in the same cycle.
- Capture and latency:
  - On the edge ending a grant cycle for port i: respi_result <= alu_result, respi_zero <= alu_zero, respi_valid <= 1.
  - Response is visible exactly 1 cycle after the request handshake.
- Drain:
  - respi_valid && respi_ready with no new grant to i clears respi_valid. result/zero hold their last values.
  - Drain and new grant in the same cycle: the slot is overwritten with the new result and respi_valid stays 1. This gives back-to-back throughput of 1 op/cycle per port when uncontended.
- Aggregate throughput: 1 op/cycle across both ports.
- Illegal ctrl 101–111: passed through unchanged; the response carries the ALU output (0, zero=1). No error flagged.
- Reset (synchronous, any time including mid-operation):
  - resp0_valid, resp1_valid = 0.
  - resp*_result = 0, resp*_zero = 0.
  - Pointer = port 0.
  - req*_ready = 0 while rst is high.
  - Undrained responses are discarded. Requests presented during reset are not accepted.
- Simultaneous requests from both ports with both slots full and no drain: no grant, both ready low, pointer holds.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined: adds outputs perf_grant0 (16b), perf_grant1 (16b) and perf_conflict (16b).
  - perf_grant0/1 count grants per port.
  - perf_conflict counts cycles where both ports were eligible.
  - All three are saturating at 16'hFFFF and cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Port 0 only, a=5, b=3, ctrl=000 → req0_ready=1 same cycle; next cycle resp0_valid=1, resp0_result=8, resp0_zero=0.
- Both ports valid from reset (FIXED_PRIO=0): p0 sub 7−7, p1 or 0|0 → cycle 0 grant p0, cycle 1 grant p1. resp0 = 0/zero=1 then resp1 = 0/zero=1. Pointer alternates on sustained contention, giving 50/50 grants over 10 cycles.
- resp1_ready held low, p1 issues slt a=32'hFFFFFFFF, b=1 → resp1_result=1. Second p1 request stalls (req1_ready=0) until resp1_ready=1. In the drain cycle it is granted and resp1_valid stays 1 with the new result.
- Port 0 back-to-back adds with resp0_ready=1 every cycle → one result per cycle, no bubbles, values in request order.
- rst asserted for 1 cycle while resp0_valid=1 and req1 pending → next cycle all resp_valid=0 and results 0. After release, p1 is granted first only if p0 is idle (pointer = port 0).
- ALU_ARB_PERF_EN: 3 contended cycles plus 2 p0-only grants → perf_conflict=3, perf_grant0=4 (2 contended under round-robin), perf_grant1=1.
